// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage MIPS pipeline.
// Optional feature: define FWD_STATS_EN to add the saturating stall_count output.
module fwd_hazard_unit (
   input  logic       clock,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [5:0] id_op,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] id_rd,
   input  logic       flush,
   output logic       stall,
   output logic [1:0] fa,
   output logic [1:0] fb
`ifdef FWD_STATS_EN
   ,
   output logic [15:0] stall_count
`endif
);

   localparam logic [5:0] ALU_OP  = 6'd0;
   localparam logic [5:0] J_OP    = 6'd2;
   localparam logic [5:0] JAL_OP  = 6'd3;
   localparam logic [5:0] BEQ_OP  = 6'd4;
   localparam logic [5:0] ADDI_OP = 6'd8;
   localparam logic [5:0] LW_OP   = 6'd35;
   localparam logic [5:0] SW_OP   = 6'd43;

   localparam logic [1:0] SEL_IDEX  = 2'b00;
   localparam logic [1:0] SEL_MEMWB = 2'b01;
   localparam logic [1:0] SEL_EXMEM = 2'b10;

   typedef struct packed {
      logic       wr;
      logic [4:0] dst;
      logic       is_lw;
   } shadow_t;

   // Index 0 = EX, 1 = MEM, 2 = WB.
   shadow_t stage [3];

   logic       id_wr;
   logic [4:0] id_dst;
   logic       id_is_lw;
   logic       uses_rs;
   logic       uses_rt;
   logic       ex_rs_hit, ex_rt_hit;
   logic       mem_rs_hit, mem_rt_hit;
   logic       hazard;
   logic       advance;
   logic [1:0] fa_next, fb_next;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      id_wr   = 1'b0;
      id_dst  = 5'd0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      case (id_op)
         ALU_OP:  begin id_wr = 1'b1; id_dst = id_rd; uses_rs = 1'b1; uses_rt = 1'b1; end
         LW_OP:   begin id_wr = 1'b1; id_dst = id_rt; uses_rs = 1'b1; end
         ADDI_OP: begin id_wr = 1'b1; id_dst = id_rt; uses_rs = 1'b1; end
         JAL_OP:  begin id_wr = 1'b1; id_dst = 5'd31; end
         SW_OP:   begin uses_rs = 1'b1; uses_rt = 1'b1; end
         BEQ_OP:  begin uses_rs = 1'b1; uses_rt = 1'b1; end
         J_OP:    ;
         default: ;
      endcase
      // $0 is hard-wired, so it is never a forwarding source.
      if (id_dst == 5'd0)
         id_wr = 1'b0;
   end

   assign id_is_lw = (id_op == LW_OP);

   assign hazard = stage[0].is_lw & stage[0].wr &
                   ((uses_rs & (id_rs == stage[0].dst)) | (uses_rt & (id_rt == stage[0].dst)));

   // Reset overrides the hazard so a pending stall drops in the reset cycle itself.
   assign stall   = ~reset & id_valid & ~flush & hazard;
   assign advance = id_valid & ~flush & ~stall;

   // A load in EX never supplies ALUOut; the stall moves it to MEM first.
   assign ex_rs_hit  = stage[0].wr & ~stage[0].is_lw & (stage[0].dst == id_rs);
   assign ex_rt_hit  = stage[0].wr & ~stage[0].is_lw & (stage[0].dst == id_rt);
   assign mem_rs_hit = stage[1].wr & (stage[1].dst == id_rs);
   assign mem_rt_hit = stage[1].wr & (stage[1].dst == id_rt);

   always_comb begin
      fa_next = SEL_IDEX;
      if (uses_rs & ex_rs_hit)       fa_next = SEL_EXMEM;
      else if (uses_rs & mem_rs_hit) fa_next = SEL_MEMWB;

      fb_next = SEL_IDEX;
      if (uses_rt & ex_rt_hit)       fb_next = SEL_EXMEM;
      else if (uses_rt & mem_rt_hit) fb_next = SEL_MEMWB;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
         stage[0] <= '0;
         stage[1] <= '0;
         stage[2] <= '0;
         fa       <= SEL_IDEX;
         fb       <= SEL_IDEX;
      end else begin
         stage[2] <= stage[1];
         stage[1] <= stage[0];
         if (advance) begin
            stage[0] <= '{wr: id_wr, dst: id_dst, is_lw: id_is_lw};
            fa       <= fa_next;
            fb       <= fb_next;
         end else begin
            stage[0] <= '0;
            fa       <= SEL_IDEX;
            fb       <= SEL_IDEX;
         end
      end
   end

`ifdef FWD_STATS_EN
   always_ff @(posedge clock) begin
      if (reset)
         stall_count <= 16'd0;
      else if (stall && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: scoreboard of expected fa/fb per EX entry.
// Covers FWD_STATS_EN counter checks when that macro is defined.
module tb_fwd_hazard_unit;

   localparam logic [5:0] ALU  = 6'd0;
   localparam logic [5:0] JAL  = 6'd3;
   localparam logic [5:0] ADDI = 6'd8;
   localparam logic [5:0] LW   = 6'd35;

   logic       clock = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [5:0] id_op;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       flush;
   logic       stall;
   logic [1:0] fa, fb;
`ifdef FWD_STATS_EN
   logic [15:0] stall_count;
`endif

   int total = 0;
   int bad   = 0;
   int exp_stalls = 0;
   logic [3:0] sb [$];

   always #5 clock = ~clock;

   fwd_hazard_unit dut (
      .clock(clock),
      .reset(reset),
      .id_valid(id_valid),
      .id_op(id_op),
      .id_rs(id_rs),
      .id_rt(id_rt),
      .id_rd(id_rd),
      .flush(flush),
      .stall(stall),
      .fa(fa),
      .fb(fb)
`ifdef FWD_STATS_EN
      ,
      .stall_count(stall_count)
`endif
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // One ID cycle: drive at edge+1, check stall mid-cycle, check fa/fb at next edge+1.
   task automatic step(input string name, input logic v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic fl, input logic exp_stall,
                       input logic [1:0] efa, input logic [1:0] efb);
      logic [3:0] exp;
      id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
      #4;
      total++;
      if (stall !== exp_stall) begin
         bad++;
         $display("FAIL %s stall: got %b want %b", name, stall, exp_stall);
      end
      if (exp_stall) exp_stalls++;
      sb.push_back({efa, efb});
      @(posedge clock);
      #1;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard: got empty queue want entry", name);
      end else begin
         exp = sb.pop_front();
         if ({fa, fb} !== exp) begin
            bad++;
            $display("FAIL %s fa/fb: got %b/%b want %b/%b", name, fa, fb, exp[3:2], exp[1:0]);
         end
      end
`ifdef FWD_STATS_EN
      total++;
      if (stall_count !== 16'(exp_stalls)) begin
         bad++;
         $display("FAIL %s stall_count: got %0d want %0d", name, stall_count, exp_stalls);
      end
`endif
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++)
         step("bubble", 1'b0, ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
   endtask

   task automatic test_reset();
      reset = 1'b1; id_valid = 1'b0; id_op = '0; id_rs = '0; id_rt = '0; id_rd = '0; flush = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      exp_stalls = 0;
      sb.delete();
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL reset stall: got %b want 0", stall); end
      total++;
      if (fa !== 2'b00 || fb !== 2'b00) begin
         bad++; $display("FAIL reset fa/fb: got %b/%b want 00/00", fa, fb);
      end
`ifdef FWD_STATS_EN
      total++;
      if (stall_count !== 16'd0) begin
         bad++; $display("FAIL reset stall_count: got %0d want 0", stall_count);
      end
`endif
      @(posedge clock);
      #1;
   endtask

   task automatic test_ex_forward();
      step("add3",        1'b1, ALU, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00);
      step("add4_rs_ex",  1'b1, ALU, 5'd3, 5'd5, 5'd4, 1'b0, 1'b0, 2'b10, 2'b00);
      bubbles(2);
   endtask

   task automatic test_mem_forward();
      step("add3",        1'b1, ALU, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00);
      step("nop",         1'b0, ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("sub_rt_mem",  1'b1, ALU, 5'd7, 5'd3, 5'd6, 1'b0, 1'b0, 2'b00, 2'b01);
      bubbles(2);
   endtask

   task automatic test_load_use();
      step("lw8",         1'b1, LW,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("add9_stall",  1'b1, ALU, 5'd8, 5'd8, 5'd9, 1'b0, 1'b1, 2'b00, 2'b00);
      step("add9_go",     1'b1, ALU, 5'd8, 5'd8, 5'd9, 1'b0, 1'b0, 2'b01, 2'b01);
      bubbles(2);
   endtask

   task automatic test_zero_and_jal();
      step("addi0",       1'b1, ADDI, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("add_00",      1'b1, ALU,  5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 2'b00, 2'b00);
      bubbles(2);
      step("jal",         1'b1, JAL,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("add_31",      1'b1, ALU,  5'd31, 5'd1, 5'd2, 1'b0, 1'b0, 2'b10, 2'b00);
      bubbles(2);
   endtask

   task automatic test_flush_priority();
      step("lw8",         1'b1, LW,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("add_flushed", 1'b1, ALU, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0, 2'b00, 2'b00);
      step("add3_a",      1'b1, ALU, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00);
      step("add3_b",      1'b1, ALU, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00);
      step("add4_newest", 1'b1, ALU, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0, 2'b10, 2'b10);
      bubbles(2);
   endtask

   task automatic test_back_to_back();
      step("lw8",         1'b1, LW,  5'd1,  5'd8,  5'd0,  1'b0, 1'b0, 2'b00, 2'b00);
      step("add9_stall",  1'b1, ALU, 5'd8,  5'd1,  5'd9,  1'b0, 1'b1, 2'b00, 2'b00);
      step("add9_go",     1'b1, ALU, 5'd8,  5'd1,  5'd9,  1'b0, 1'b0, 2'b01, 2'b00);
      step("lw10_fwd9",   1'b1, LW,  5'd9,  5'd10, 5'd0,  1'b0, 1'b0, 2'b10, 2'b00);
      step("add11_stall", 1'b1, ALU, 5'd10, 5'd10, 5'd11, 1'b0, 1'b1, 2'b00, 2'b00);
      step("add11_go",    1'b1, ALU, 5'd10, 5'd10, 5'd11, 1'b0, 1'b0, 2'b01, 2'b01);
      bubbles(2);
   endtask

   task automatic test_reset_mid_stall();
      step("lw8",         1'b1, LW,  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
      id_valid = 1'b1; id_op = ALU; id_rs = 5'd8; id_rt = 5'd8; id_rd = 5'd9; flush = 1'b0;
      #4;
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL midrst pre stall: got %b want 1", stall); end
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_stalls = 0;
      sb.delete();
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL midrst stall: got %b want 0", stall); end
      total++;
      if (fa !== 2'b00 || fb !== 2'b00) begin
         bad++; $display("FAIL midrst fa/fb: got %b/%b want 00/00", fa, fb);
      end
`ifdef FWD_STATS_EN
      total++;
      if (stall_count !== 16'd0) begin
         bad++; $display("FAIL midrst stall_count: got %0d want 0", stall_count);
      end
`endif
      step("add9_after",  1'b1, ALU, 5'd8, 5'd8, 5'd9, 1'b0, 1'b0, 2'b00, 2'b00);
      bubbles(1);
   endtask

   initial begin
      test_reset();
      test_ex_forward();
      test_mem_forward();
      test_load_use();
      test_zero_and_jal();
      test_flush_priority();
      test_back_to_back();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard unit for the 5-stage MIPS pipeline. It tracks the destination register and write-enable of every instruction in EX, MEM and WB with internal shadow registers. It produces the registered 2-bit forward selects `fa`/`fb` consumed by the ALU input-A/input-B muxes during EX, and raises a one-cycle `stall` on load-use hazards. It sits between the ID/EX pipeline register logic and the EX-stage operand muxes.

## Interface
- No parameters; opcode constants are the pipeline's: ALUop=6'd0, Jop=6'd2, JALop=6'd3, BEQ=6'd4, ADD_IMM=6'd8, LW=6'd35, SW=6'd43.
- `clock`  in  1  pipeline clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_op`  in  6  ID instruction [31:26].
- `id_rs`  in  5  ID instruction [25:21].
- `id_rt`  in  5  ID instruction [20:16].
- `id_rd`  in  5  ID instruction [15:11].
- `flush`  in  1  squash the ID instruction (taken branch/jump resolved in EX).
- `stall`  out  1  combinational; hold PC and IF/ID, insert bubble into EX.
- `fa`  out  2  registered select for ALU input A: 00 IDEXA, 01 MEMWBValue, 10 EXMEMALUOut.
- `fb`  out  2  registered select for ALU input B, same encoding.
- `stall_count`  out  16  load-use stall counter (only with `FWD_STATS_EN`).

## Operation
- Three shadow stages (EX, MEM, WB), each holding `wr` (1 bit), `dst` (5 bits) and `is_lw` (1 bit).
- Decode at ID:
  - ALUop writes `rd`.
  - LW and ADD_IMM write `rt`.
  - JALop writes 31.
  - SW, BEQ and Jop write nothing.
  - `dst==0` forces `wr=0`.
- Operand use at ID:
  - `rs` is read by ALUop, LW, SW, ADD_IMM and BEQ.
  - `rt` is read by ALUop, SW and BEQ.
- Hazard: `stall = id_valid & ~flush & EX.is_lw & EX.wr & ((uses_rs & id_rs==EX.dst) | (uses_rt & id_rt==EX.dst))`.
- Each rising edge, unless reset:
  - WB<=MEM and MEM<=EX.
  - EX<=decoded ID instruction if `id_valid & ~flush & ~stall`, else a bubble (`wr=0`, `is_lw=0`).
- Forward select for `fa`, computed at the same edge from the ID operand `rs`:
  - 10 if uses_rs & EX.wr & EX.dst==id_rs.
  - Else 01 if uses_rs & MEM.wr & MEM.dst==id_rs.
  - Else 00.
  - `fb` uses the same rule with `rt`/uses_rt.
  - Bubbles load `fa=fb=00`.
- Priority: the newest producer (EX/MEM) always beats MEM/WB when both match.
- LW in EX/MEM is never forwarded as ALUOut. The stall guarantees the LW has reached MEM/WB before the consumer enters EX, so that consumer gets 01.
- Register 0 is never forwarded.

## Timing
- Reset values: all shadow `wr`/`is_lw`=0, `fa`=`fb`=00, `stall_count`=0. `stall`=0 follows combinationally.
- `fa`/`fb` change only on a clock edge. They are valid for the whole cycle the instruction occupies EX, so there is zero added pipeline latency.
- `stall` lasts exactly one cycle per load-use pair. On the next cycle the LW has moved to MEM, the hazard clears, and the consumer advances.
- Simultaneous `flush` and hazard: `flush` wins. `stall`=0 and a bubble enters EX.
- Reset mid-stall: `stall` drops the same cycle reset is sampled, and all shadows clear.
- Back-to-back LW→consumer pairs each stall once. Independent instructions never stall.

## Configuration
- `FWD_STATS_EN` defined:
  - `stall_count` increments on every cycle with `stall`=1 and saturates at 16'hFFFF.
  - It is cleared only by reset.
- Not defined: the port `stall_count` is absent, and there is no counter logic.

## Test plan
- Reset, then `add $3,$1,$2` followed by `add $4,$3,$5` → second instruction in EX with `fa`=10, `fb`=00, `stall` never asserted.
- `add $3`, `nop`, `sub $6,$7,$3` → `sub` in EX with `fa`=00, `fb`=01.
- `lw $8,0($1)` then `add $9,$8,$8` → `stall`=1 for exactly one cycle, then `add` enters EX with `fa`=`fb`=01. `stall_count`=1 when `FWD_STATS_EN` is defined.
- `addi $0,$1,5` then `add $2,$0,$0` → `fa`=`fb`=00 (no $0 forwarding). Also: `jal` then `add $2,$31,$1` → `fa`=10.
- `lw $8` then `add $9,$8,$1` with `flush`=1 on the `add` cycle → `stall`=0 and a bubble enters EX. Also: `add $3` twice then `add $4,$3,$3` → `fa`=`fb`=10 (newest wins).
- Assert `reset` during a stall cycle → next cycle `stall`=0, `fa`=`fb`=00, `stall_count`=0.
